wired_cdb_arbiter: RTL and testbench

//  Schedules completed results from the ALU, LSU and MDU back-ends onto the two CDB lanes.

---
 rtl/wired_cdb_arbiter_if.sv | 42 ++++
 rtl/wired_cdb_arbiter.sv | 116 +++++++++++
 tb/tb_wired_cdb_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wired_cdb_arbiter_if.sv
// CDB arbiter bus: result payload type plus the source/lane handshake bundle.
// "master" is the side that owns the back-end sources; "slave" is the arbiter.

package wired_cdb_pkg;

  // One completed result as broadcast on a CDB lane; wid[0] selects the ROB bank.
  typedef struct packed {
    logic        valid;
    logic [6:0]  wid;
    logic [31:0] data;
  } pipeline_cdb_t;

endpackage

interface wired_cdb_arbiter_if #(
  parameter int SRC_CNT = 4
);
  import wired_cdb_pkg::*;

  logic                        flush_i;
  logic [SRC_CNT-1:0]          src_valid_i;
  logic [SRC_CNT-1:0]          src_ready_o;
  pipeline_cdb_t [SRC_CNT-1:0] src_cdb_i;
  pipeline_cdb_t [1:0]         cdb_o;

  modport master (
    output flush_i,
    output src_valid_i,
    output src_cdb_i,
    input  src_ready_o,
    input  cdb_o
  );

  modport slave (
    input  flush_i,
    input  src_valid_i,
    input  src_cdb_i,
    output src_ready_o,
    output cdb_o
  );

endinterface

// File: rtl/wired_cdb_arbiter.sv
// Two-lane CDB arbiter. Each source targets the lane matching its ROB bank
// (wid[0]); each lane picks a winner by fixed priority (lowest index first),
// except that sources stalled STARVE_LIMIT cycles in a row are promoted ahead
// of all unpromoted ones. Grants are accepted unconditionally and the chosen
// payloads are registered onto cdb_o one cycle later.

module wired_cdb_arbiter
  import wired_cdb_pkg::*;
#(
  parameter int SRC_CNT      = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wired_cdb_arbiter_if.slave    bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]       starve_q [SRC_CNT];
  logic [SRC_CNT-1:0]  promo;
  logic [SRC_CNT-1:0]  req      [2];
  logic [1:0]          lane_gnt;
  logic [IW-1:0]       lane_win [2];
  logic [SRC_CNT-1:0]  grant;
  pipeline_cdb_t [1:0] cdb_q;

  // Split requests by target bank and flag sources that have hit the starvation limit.
  always_comb begin
    req[0] = '0;
    req[1] = '0;
    promo  = '0;
    for (int i = 0; i < SRC_CNT; i++) begin
      promo[i]  = (starve_q[i] == LIMIT);
      req[0][i] = bus.src_valid_i[i] && (bus.src_cdb_i[i].wid[0] == 1'b0);
      req[1][i] = bus.src_valid_i[i] && (bus.src_cdb_i[i].wid[0] == 1'b1);
    end
  end

  // Per-lane winner: promoted requesters first, then plain fixed priority; flush blocks all grants.
  always_comb begin
    lane_gnt    = 2'b00;
    lane_win[0] = '0;
    lane_win[1] = '0;
    grant       = '0;
    for (int b = 0; b < 2; b++) begin
      // Scan from the highest index down so the lowest requester is the last (winning) write.
      for (int i = SRC_CNT - 1; i >= 0; i--) begin
        if (req[b][i]) begin
          lane_gnt[b] = 1'b1;
          lane_win[b] = IW'(i);
        end else begin
          lane_gnt[b] = lane_gnt[b];
        end
      end
      // A promoted requester overrides the plain pick; again lowest index wins.
      for (int i = SRC_CNT - 1; i >= 0; i--) begin
        if (req[b][i] && promo[i]) begin
          lane_win[b] = IW'(i);
        end else begin
          lane_gnt[b] = lane_gnt[b];
        end
      end
      if (lane_gnt[b] && !bus.flush_i) begin
        grant[lane_win[b]] = 1'b1;
      end else begin
        grant = grant;
      end
    end
  end

  // Ready is the grant itself: the CDB never back-pressures, so a grant is a transfer.
  assign bus.src_ready_o = grant;

  // Output lanes: capture the winner's payload, or drop valid and keep the old payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_q <= '0;
    end else if (bus.flush_i) begin
      for (int b = 0; b < 2; b++) begin
        cdb_q[b].valid <= 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (lane_gnt[b]) begin
          cdb_q[b]       <= bus.src_cdb_i[lane_win[b]];
          cdb_q[b].valid <= 1'b1;
        end else begin
          cdb_q[b].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.cdb_o = cdb_q;

  // Starvation counters: count consecutive stalled cycles, saturate at the limit, clear otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_i) begin
      for (int i = 0; i < SRC_CNT; i++) begin
        starve_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SRC_CNT; i++) begin
        if (bus.src_valid_i[i] && !grant[i]) begin
          starve_q[i] <= (starve_q[i] == LIMIT) ? LIMIT : starve_q[i] + CW'(1);
        end else begin
          starve_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Self-checking bench for wired_cdb_arbiter: a directed vector table, hand
// sequences for starvation/flush/reset corners, and a randomized run checked
// against a candidate-list reference model.

module tb_wired_cdb_arbiter;
  import wired_cdb_pkg::*;

  localparam int SRC_CNT = 4;
  localparam int LIMIT   = 7;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wired_cdb_arbiter_if #(.SRC_CNT(SRC_CNT)) bus ();

  wired_cdb_arbiter #(.SRC_CNT(SRC_CNT), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               wait_cnt [SRC_CNT];
  bit               m_valid  [2];
  pipeline_cdb_t    m_cdb    [2];
  logic [SRC_CNT-1:0] exp_ready;
  int               exp_win  [2];

  typedef struct packed {
    logic [3:0]      valid;
    logic [3:0][6:0] wid;
    logic            flush;
    logic [3:0]      exp_ready;
    logic [1:0]      exp_lv;
    logic [1:0][6:0] exp_wid;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Winner per lane: build the ordered candidate list (promoted sources, then the rest).
  function automatic void model_pick();
    int q[$];
    for (int b = 0; b < 2; b++) begin
      q.delete();
      exp_win[b] = -1;
      for (int i = 0; i < SRC_CNT; i++)
        if (bus.src_valid_i[i] && bus.src_cdb_i[i].wid[0] == b[0] && wait_cnt[i] == LIMIT) q.push_back(i);
      for (int i = 0; i < SRC_CNT; i++)
        if (bus.src_valid_i[i] && bus.src_cdb_i[i].wid[0] == b[0] && wait_cnt[i] != LIMIT) q.push_back(i);
      if (q.size() > 0) exp_win[b] = q[0];
    end
    exp_ready = '0;
    if (!bus.flush_i)
      for (int b = 0; b < 2; b++)
        if (exp_win[b] >= 0) exp_ready[exp_win[b]] = 1'b1;
  endfunction

  function automatic void model_update();
    if (!rst_n || bus.flush_i) begin
      for (int b = 0; b < 2; b++) m_valid[b] = 1'b0;
      for (int i = 0; i < SRC_CNT; i++) wait_cnt[i] = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_valid[b] = (exp_win[b] >= 0);
        if (exp_win[b] >= 0) m_cdb[b] = bus.src_cdb_i[exp_win[b]];
      end
      for (int i = 0; i < SRC_CNT; i++)
        if (bus.src_valid_i[i] && !exp_ready[i]) wait_cnt[i] = (wait_cnt[i] >= LIMIT) ? LIMIT : wait_cnt[i] + 1;
        else wait_cnt[i] = 0;
    end
  endfunction

  // One clock: check ready mid-cycle, advance the model at the edge, check registered outputs after.
  task automatic step();
    @(negedge clk);
    model_pick();
    chk("src_ready", 64'(bus.src_ready_o), 64'(exp_ready));
    @(posedge clk);
    model_update();
    #1;
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("lane%0d_valid", b), 64'(bus.cdb_o[b].valid), 64'(m_valid[b]));
      if (m_valid[b])
        chk($sformatf("lane%0d_payload", b), 64'({bus.cdb_o[b].wid, bus.cdb_o[b].data}),
            64'({m_cdb[b].wid, m_cdb[b].data}));
    end
    for (int i = 0; i < SRC_CNT; i++)
      chk($sformatf("starve%0d", i), 64'(dut.starve_q[i]), 64'(wait_cnt[i]));
  endtask

  task automatic set_src(input int i, input bit v, input logic [6:0] wid);
    bus.src_valid_i[i]     = v;
    bus.src_cdb_i[i].wid   = wid;
    bus.src_cdb_i[i].data  = $urandom;
    bus.src_cdb_i[i].valid = 1'($urandom);
  endtask

  task automatic idle();
    for (int i = 0; i < SRC_CNT; i++) set_src(i, 1'b0, 7'h00);
    bus.flush_i = 1'b0;
    step();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.flush_i     = 1'b0;
    bus.src_valid_i = '0;
    bus.src_cdb_i   = '0;
    for (int i = 0; i < SRC_CNT; i++) wait_cnt[i] = 0;
    for (int b = 0; b < 2; b++) begin m_valid[b] = 1'b0; m_cdb[b] = '0; exp_win[b] = -1; end

    vecs[0] = '{valid:4'b0011, wid:{7'h00,7'h00,7'h21,7'h10}, flush:1'b0, exp_ready:4'b0011, exp_lv:2'b11, exp_wid:{7'h21,7'h10}};
    vecs[1] = '{valid:4'b0101, wid:{7'h00,7'h12,7'h00,7'h10}, flush:1'b0, exp_ready:4'b0001, exp_lv:2'b01, exp_wid:{7'h00,7'h10}};
    vecs[2] = '{valid:4'b1111, wid:{7'h16,7'h14,7'h12,7'h10}, flush:1'b0, exp_ready:4'b0001, exp_lv:2'b01, exp_wid:{7'h00,7'h10}};
    vecs[3] = '{valid:4'b1111, wid:{7'h17,7'h15,7'h13,7'h11}, flush:1'b0, exp_ready:4'b0001, exp_lv:2'b10, exp_wid:{7'h11,7'h00}};
    vecs[4] = '{valid:4'b1100, wid:{7'h33,7'h22,7'h00,7'h00}, flush:1'b0, exp_ready:4'b1100, exp_lv:2'b11, exp_wid:{7'h33,7'h22}};
    vecs[5] = '{valid:4'b1110, wid:{7'h24,7'h23,7'h21,7'h00}, flush:1'b0, exp_ready:4'b1010, exp_lv:2'b11, exp_wid:{7'h21,7'h24}};
    vecs[6] = '{valid:4'b1111, wid:{7'h17,7'h14,7'h13,7'h10}, flush:1'b1, exp_ready:4'b0000, exp_lv:2'b00, exp_wid:{7'h00,7'h00}};
    vecs[7] = '{valid:4'b0000, wid:{7'h00,7'h00,7'h00,7'h00}, flush:1'b0, exp_ready:4'b0000, exp_lv:2'b00, exp_wid:{7'h00,7'h00}};
    vecs[8] = '{valid:4'b1000, wid:{7'h35,7'h00,7'h00,7'h00}, flush:1'b0, exp_ready:4'b1000, exp_lv:2'b10, exp_wid:{7'h35,7'h00}};
    vecs[9] = '{valid:4'b0110, wid:{7'h00,7'h12,7'h13,7'h00}, flush:1'b0, exp_ready:4'b0110, exp_lv:2'b11, exp_wid:{7'h13,7'h12}};

    // Reset state
    step();
    step();
    chk("reset_lane0_valid", 64'(bus.cdb_o[0].valid), 64'd0);
    chk("reset_lane1_valid", 64'(bus.cdb_o[1].valid), 64'd0);
    rst_n = 1'b1;
    idle();

    // Directed vector table, each followed by an idle cycle so counters restart at 0
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < SRC_CNT; i++) set_src(i, vecs[v].valid[i], vecs[v].wid[i]);
      bus.flush_i = vecs[v].flush;
      #2;
      chk($sformatf("vec%0d_ready", v), 64'(bus.src_ready_o), 64'(vecs[v].exp_ready));
      step();
      for (int b = 0; b < 2; b++) begin
        chk($sformatf("vec%0d_lane%0d_valid", v, b), 64'(bus.cdb_o[b].valid), 64'(vecs[v].exp_lv[b]));
        if (vecs[v].exp_lv[b])
          chk($sformatf("vec%0d_lane%0d_wid", v, b), 64'(bus.cdb_o[b].wid), 64'(vecs[v].exp_wid[b]));
      end
      idle();
    end

    // ALU0 floods bank 0; MDU stalls 7 cycles and wins on the 8th
    set_src(3, 1'b1, 7'h30);
    for (int c = 1; c <= 8; c++) begin
      set_src(0, 1'b1, 7'h10);
      #2;
      chk($sformatf("starve_c%0d_ready", c), 64'(bus.src_ready_o), (c == 8) ? 64'h8 : 64'h1);
      step();
    end
    chk("starve_mdu_lane0_wid", 64'(bus.cdb_o[0].wid), 64'h30);
    set_src(3, 1'b0, 7'h00);
    set_src(0, 1'b1, 7'h10);
    #2;
    chk("starve_alu0_back", 64'(bus.src_ready_o), 64'h1);
    step();
    idle();

    // LSU and MDU both promoted on bank 1 behind a flooding ALU1
    set_src(2, 1'b1, 7'h23);
    set_src(3, 1'b1, 7'h35);
    for (int c = 1; c <= 7; c++) begin
      set_src(1, 1'b1, 7'h11);
      #2;
      chk($sformatf("dual_c%0d_ready", c), 64'(bus.src_ready_o), 64'h2);
      step();
    end
    set_src(1, 1'b1, 7'h11);
    #2;
    chk("dual_lsu_first", 64'(bus.src_ready_o), 64'h4);
    step();
    chk("dual_lsu_wid", 64'(bus.cdb_o[1].wid), 64'h23);
    set_src(2, 1'b0, 7'h00);
    #2;
    chk("dual_mdu_next", 64'(bus.src_ready_o), 64'h8);
    step();
    chk("dual_mdu_wid", 64'(bus.cdb_o[1].wid), 64'h35);
    idle();

    // Flush with all four sources valid and counters running
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < SRC_CNT; i++) set_src(i, 1'b1, 7'(8'h10 + 8'(2 * i)));
      step();
    end
    bus.flush_i = 1'b1;
    #2;
    chk("flush_ready", 64'(bus.src_ready_o), 64'h0);
    step();
    chk("flush_lane0_valid", 64'(bus.cdb_o[0].valid), 64'd0);
    chk("flush_lane1_valid", 64'(bus.cdb_o[1].valid), 64'd0);
    for (int i = 0; i < SRC_CNT; i++) chk($sformatf("flush_cnt%0d", i), 64'(dut.starve_q[i]), 64'd0);
    idle();

    // Reset mid-stream with MDU counter at 5
    set_src(3, 1'b1, 7'h30);
    for (int c = 0; c < 5; c++) begin
      set_src(0, 1'b1, 7'h10);
      step();
    end
    chk("rst_mdu_cnt5", 64'(dut.starve_q[3]), 64'd5);
    set_src(0, 1'b1, 7'h10);
    rst_n = 1'b0;
    step();
    chk("rst_lane0_valid", 64'(bus.cdb_o[0].valid), 64'd0);
    chk("rst_lane1_valid", 64'(bus.cdb_o[1].valid), 64'd0);
    chk("rst_mdu_cnt0", 64'(dut.starve_q[3]), 64'd0);
    rst_n = 1'b1;
    set_src(0, 1'b1, 7'h10);
    #2;
    chk("rst_no_stale_grant", 64'(bus.src_ready_o), 64'h1);
    step();
    idle();

    // Randomized traffic against the model; stalled sources hold their payload
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < SRC_CNT; i++) begin
        if (!(bus.src_valid_i[i] && !exp_ready[i]))
          set_src(i, ($urandom_range(0, 99) < 75), 7'($urandom));
      end
      bus.flush_i = ($urandom_range(0, 39) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
